factorial_seq: RTL and testbench
================================

// Module: factorial_seq
// PURPOSE
//   Parametrised sequential factorial / double-factorial engine: successor of the
//   single-width repeated-addition factorial unit. Accepts an operand on a start
//   strobe, computes x! or x!! with a bit-serial shift-add multiplier, and reports
//   the result with a one-cycle done pulse and a sticky overflow flag.
// PARAMETERS
//   WIDTH     32  operand/result width in bits (>= 4)
//   SATURATE  0   1: result forced to all-ones when overflow; 0: result is product mod 2^WIDTH
// PORTS
//   clock     in   1      single clock, all state on posedge
//   reset     in   1      synchronous, active-low reset
//   start     in   1      request; sampled only in IDLE
//   mode      in   1      0: x! (step 1); 1: x!! (step 2); latched with x on accept
//   x         in   WIDTH  operand, unsigned; latched on accept
//   busy      out  1      high whenever state != IDLE
//   done      out  1      one-cycle pulse, result/overflow valid in the same cycle
//   result    out  WIDTH  final value; held from done until next accept
//   overflow  out  1      any partial product exceeded WIDTH bits; held with result
// BEHAVIOUR
//   - Reset (reset==0 at posedge): state<=IDLE; busy, done, result, overflow <= 0;
//     internal acc, k, prod, bit counter <= 0. Applies mid-computation: job discarded.
//   - States: IDLE, MUL, STEP, DONE. step = mode ? 2 : 1.
//   - IDLE & start (accept edge E0): latch mode; acc <= (x>1) ? x : 1; k <= x-step;
//     overflow_int <= 0; next = (x>1 && x-step>1) ? MUL : DONE. start ignored otherwise.
//   - MUL: WIDTH cycles, bit i = 0..WIDTH-1 of k, LSB first;
//     prod (2*WIDTH bits, cleared on entry) += k[i] ? (acc << i) : 0. Then -> STEP.
//   - STEP (1 cycle): overflow_int |= (prod[2W-1:W] != 0); acc <= prod[W-1:0];
//     k <= k-step; next = (k-step > 1) ? MUL : DONE. Wrapped acc is reused after overflow.
//   - DONE (1 cycle): done=1; result = (SATURATE && overflow_int) ? '1 : acc;
//     overflow = overflow_int; both registered on DONE entry. Always -> IDLE.
//   - Multiplies m = count of k in {x-step, x-2*step, ...} with k > 1; m=0 if x<=1.
//     done asserted exactly m*(WIDTH+1)+1 cycles after E0. m = x-2 for x! (x>=2).
//   - Boundaries: x=0 or 1 -> result 1, m=0. x=2 (either mode) -> 2, m=0.
//     mode 1 with k reaching 0 or 1 terminates without extra multiply.
//   - start held high continuously: new accept only on the IDLE cycle after DONE,
//     i.e. back-to-back jobs separated by exactly one IDLE cycle.
//   - x/mode changes while busy have no effect. done never asserted outside DONE.
// TESTING (WIDTH=8 unless noted)
//   5, mode0 -> done 28 cycles after accept, result 120, overflow 0, busy high 28 cycles
//   6, mode0 -> result 208 (720 mod 256), overflow 1; with SATURATE=1 -> 255, overflow 1
//   7, mode1 -> result 105, overflow 0, done 19 cycles after accept (m=2)
//   x=0 and x=1 (each mode) -> done 1 cycle after accept, result 1; x=2 -> result 2
//   start re-pulsed mid-MUL with x=3 -> ignored, original result delivered; reset low
//     mid-MUL -> next edge busy/done/result/overflow all 0, fresh start then runs normally
//   WIDTH=32: 12, mode0 -> 479001600, overflow 0; 13, mode0 -> 1932053504, overflow 1

Source files
------------

// File: rtl/factorial_seq.sv
// Sequential factorial / double-factorial engine using a bit-serial shift-add multiplier.
// One-cycle done pulse with result and sticky overflow; optional saturation on overflow.
module factorial_seq #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, STEP, DONE} state_t;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic             ovf_int_q, ovf_int_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] step_in;
  logic [WIDTH-1:0] step_cur;
  logic [WIDTH-1:0] k_first;
  logic [WIDTH-1:0] k_next;

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    k_d        = k_q;
    prod_d     = prod_q;
    bit_d      = bit_q;
    ovf_int_d  = ovf_int_q;
    done_d     = 1'b0;
    result_d   = result_q;
    overflow_d = overflow_q;

    step_in  = mode   ? WIDTH'(2) : WIDTH'(1);
    step_cur = mode_q ? WIDTH'(2) : WIDTH'(1);
    k_first  = x - step_in;
    k_next   = k_q - step_cur;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d    = mode;
          acc_d     = (x > WIDTH'(1)) ? x : WIDTH'(1);
          k_d       = k_first;
          ovf_int_d = 1'b0;
          prod_d    = '0;
          bit_d     = '0;
          state_d   = ((x > WIDTH'(1)) && (k_first > WIDTH'(1))) ? MUL : DONE;
        end
      end
      MUL: begin
        if (k_q[bit_q]) begin
          prod_d = prod_q + (PW'(acc_q) << bit_q);
        end
        bit_d = bit_q + CW'(1);
        if (bit_q == CW'(WIDTH - 1)) begin
          bit_d   = '0;
          state_d = STEP;
        end
      end
      STEP: begin
        // Wrapped low half is carried forward even after an overflow
        ovf_int_d = ovf_int_q | (prod_q[PW-1:WIDTH] != '0);
        acc_d     = prod_q[WIDTH-1:0];
        k_d       = k_next;
        prod_d    = '0;
        state_d   = (k_next > WIDTH'(1)) ? MUL : DONE;
      end
      DONE: begin
        done_d     = 1'b1;
        result_d   = (SATURATE && ovf_int_q) ? '1 : acc_q;
        overflow_d = ovf_int_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      acc_q      <= '0;
      k_q        <= '0;
      prod_q     <= '0;
      bit_q      <= '0;
      ovf_int_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      acc_q      <= acc_d;
      k_q        <= k_d;
      prod_q     <= prod_d;
      bit_q      <= bit_d;
      ovf_int_q  <= ovf_int_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_factorial_seq.sv
// Self-checking bench for factorial_seq: 8-bit wrap, 8-bit saturate and 32-bit instances
// checked against an arithmetic reference of the factorial / double-factorial rules.
module tb_factorial_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, start32, mode;
  logic [7:0]  x8;
  logic [31:0] x32;
  logic        busy8, done8, ovf8;
  logic [7:0]  res8;
  logic        busy8s, done8s, ovf8s;
  logic [7:0]  res8s;
  logic        busy32, done32, ovf32;
  logic [31:0] res32;

  int checks = 0;
  int errors = 0;

  logic [31:0] got8, got8s, got32;
  logic        gov8, gov8s, gov32;
  int          lat8, lat32;

  always #5 clk = ~clk;

  factorial_seq #(.WIDTH(8), .SATURATE(1'b0)) dut8 (
    .clock(clk), .reset(rst_n), .start(start8), .mode(mode), .x(x8),
    .busy(busy8), .done(done8), .result(res8), .overflow(ovf8));

  factorial_seq #(.WIDTH(8), .SATURATE(1'b1)) dut8s (
    .clock(clk), .reset(rst_n), .start(start8), .mode(mode), .x(x8),
    .busy(busy8s), .done(done8s), .result(res8s), .overflow(ovf8s));

  factorial_seq #(.WIDTH(32), .SATURATE(1'b0)) dut32 (
    .clock(clk), .reset(rst_n), .start(start32), .mode(mode), .x(x32),
    .busy(busy32), .done(done32), .result(res32), .overflow(ovf32));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Product of x, x-step, x-2*step ... (terms > 1), wrapped to w bits after each multiply
  function automatic void ref_model(input longint unsigned xv, input bit mv, input int w,
                                    output longint unsigned res, output bit ovf, output int m);
    longint unsigned mask, acc, p;
    longint          k, step;
    mask = (64'd1 << w) - 64'd1;
    step = mv ? 2 : 1;
    acc  = (xv > 1) ? xv : 64'd1;
    ovf  = 1'b0;
    m    = 0;
    if (xv > 1) begin
      for (k = longint'(xv) - step; k > 1; k -= step) begin
        p = acc * longint'(k);
        if (p > mask) ovf = 1'b1;
        acc = p & mask;
        m++;
      end
    end
    res = acc;
  endfunction

  task automatic run_job(input logic [31:0] xv, input bit mv, input bit use32);
    longint unsigned r8, r32;
    bit              o8, o32;
    int              m8, m32, cyc, busy_cnt;
    ref_model(longint'(xv[7:0]), mv, 8, r8, o8, m8);
    ref_model(longint'(xv), mv, 32, r32, o32, m32);
    x8 = xv[7:0]; x32 = xv; mode = mv;
    start8 = 1'b1; start32 = use32;
    @(posedge clk); #1;
    start8 = 1'b0; start32 = 1'b0;
    cyc = 0; busy_cnt = busy8 ? 1 : 0;
    lat8 = -1; lat32 = -1;
    got8 = '0; got8s = '0; got32 = '0; gov8 = 1'b0; gov8s = 1'b0; gov32 = 1'b0;
    while ((lat8 < 0 || (use32 && lat32 < 0)) && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (lat8 < 0 && busy8) busy_cnt++;
      if (lat8 < 0 && done8) begin
        lat8 = cyc; got8 = 32'(res8); gov8 = ovf8; got8s = 32'(res8s); gov8s = ovf8s;
      end
      if (use32 && lat32 < 0 && done32) begin
        lat32 = cyc; got32 = res32; gov32 = ovf32;
      end
    end
    check($sformatf("lat8 x=%0d m=%0d", xv, mv), 64'(lat8), 64'(m8 * 9 + 1));
    check($sformatf("busy8 x=%0d m=%0d", xv, mv), 64'(busy_cnt), 64'(m8 * 9 + 1));
    check($sformatf("res8 x=%0d m=%0d", xv, mv), 64'(got8), 64'(r8));
    check($sformatf("ovf8 x=%0d m=%0d", xv, mv), 64'(gov8), 64'(o8));
    check($sformatf("res8s x=%0d m=%0d", xv, mv), 64'(got8s), o8 ? 64'd255 : 64'(r8));
    check($sformatf("ovf8s x=%0d m=%0d", xv, mv), 64'(gov8s), 64'(o8));
    if (use32) begin
      check($sformatf("lat32 x=%0d m=%0d", xv, mv), 64'(lat32), 64'(m32 * 33 + 1));
      check($sformatf("res32 x=%0d m=%0d", xv, mv), 64'(got32), 64'(r32));
      check($sformatf("ovf32 x=%0d m=%0d", xv, mv), 64'(gov32), 64'(o32));
    end
    @(posedge clk); #1;
    check("done8 pulse width", 64'(done8), 64'd0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start8 = 1'b0; start32 = 1'b0; mode = 1'b0; x8 = '0; x32 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy8", 64'(busy8), 64'd0);
    check("reset done8", 64'(done8), 64'd0);
    check("reset res8", 64'(res8), 64'd0);
    check("reset ovf8", 64'(ovf8), 64'd0);
    check("reset res32", 64'(res32), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(32'd5, 1'b0, 1'b1);
    check("5! value", 64'(got8), 64'd120);
    check("5! latency", 64'(lat8), 64'd28);
    check("5! value w32", 64'(got32), 64'd120);

    run_job(32'd6, 1'b0, 1'b0);
    check("6! wrapped", 64'(got8), 64'd208);
    check("6! overflow", 64'(gov8), 64'd1);
    check("6! saturated", 64'(got8s), 64'd255);

    run_job(32'd7, 1'b1, 1'b0);
    check("7!! value", 64'(got8), 64'd105);
    check("7!! latency", 64'(lat8), 64'd19);

    for (int xv = 0; xv <= 2; xv++) begin
      for (int mv = 0; mv <= 1; mv++) begin
        run_job(32'(xv), 1'(mv), 1'b0);
        check($sformatf("small x=%0d mode=%0d value", xv, mv), 64'(got8), (xv == 2) ? 64'd2 : 64'd1);
        check($sformatf("small x=%0d mode=%0d latency", xv, mv), 64'(lat8), 64'd1);
      end
    end

    run_job(32'd12, 1'b0, 1'b1);
    check("12! w32", 64'(got32), 64'd479001600);
    check("12! w32 ovf", 64'(gov32), 64'd0);
    run_job(32'd13, 1'b0, 1'b1);
    check("13! w32", 64'(got32), 64'd1932053504);
    check("13! w32 ovf", 64'(gov32), 64'd1);

    // Start re-pulsed with a different operand while multiplying
    x8 = 8'd5; mode = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; cyc = 0;
    repeat (3) begin @(posedge clk); #1; cyc++; end
    x8 = 8'd3; start8 = 1'b1;
    @(posedge clk); #1; cyc++;
    start8 = 1'b0;
    while (!done8 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check("repulse latency", 64'(cyc), 64'd28);
    check("repulse result", 64'(res8), 64'd120);
    check("repulse ovf", 64'(ovf8), 64'd0);

    // Reset asserted mid-computation
    x8 = 8'd6; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset busy8", 64'(busy8), 64'd0);
    check("midreset done8", 64'(done8), 64'd0);
    check("midreset res8", 64'(res8), 64'd0);
    check("midreset ovf8", 64'(ovf8), 64'd0);
    check("midreset res8s", 64'(res8s), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(32'd4, 1'b0, 1'b0);
    check("post-reset 4!", 64'(got8), 64'd24);

    // Start held high: next accept on the single idle cycle after done
    x8 = 8'd3; mode = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!done8 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check("held first latency", 64'(cyc), 64'd10);
    check("held idle gap", 64'(busy8), 64'd0);
    @(posedge clk); #1;
    check("held reaccept", 64'(busy8), 64'd1);
    start8 = 1'b0; cyc = 0;
    while (!done8 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check("held second latency", 64'(cyc), 64'd10);
    check("held second result", 64'(res8), 64'd6);
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      run_job(32'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
